// File: rtl/pixel_bus_receiver_if.sv
// pixel_bus_receiver_if
// Shared pixel draw bus (drawer side) plus the plot/ready framebuffer
// handshake (adapter side) of the pixel bus receiver.
//   slave  : view taken by the receiver
//   master : view taken by whatever drives the draw bus and owns fb_ready
interface pixel_bus_receiver_if #(
  parameter int COLOUR_BITS = 3
);
  // Draw bus; the strobe floats when no drawer is active
  logic                   vga_draw_enable_bus;
  logic [7:0]             vga_x_out_bus;
  logic [7:0]             vga_y_out_bus;
  logic [23:0]            vga_RGB_out_bus;

  // Framebuffer side
  logic [7:0]             fb_x;
  logic [6:0]             fb_y;
  logic [COLOUR_BITS-1:0] fb_colour;
  logic                   fb_plot;
  logic                   fb_ready;

  modport slave (
    input  vga_draw_enable_bus,
    input  vga_x_out_bus,
    input  vga_y_out_bus,
    input  vga_RGB_out_bus,
    input  fb_ready,
    output fb_x,
    output fb_y,
    output fb_colour,
    output fb_plot
  );

  modport master (
    output vga_draw_enable_bus,
    output vga_x_out_bus,
    output vga_y_out_bus,
    output vga_RGB_out_bus,
    output fb_ready,
    input  fb_x,
    input  fb_y,
    input  fb_colour,
    input  fb_plot
  );
endinterface

// File: rtl/pixel_bus_receiver.sv
// pixel_bus_receiver
// Sink of the shared pixel draw bus. Each valid draw strobe is clipped to
// the screen, reduced in colour depth and queued in a small FIFO; a
// two-state output stage hands pixels to the framebuffer one at a time over
// a plot/ready handshake so drawers never have to stall.
// Optional feature: define CLIP_COUNT_EN to add a saturating 16-bit
// clip_count output that counts discarded off-screen strobes.
module pixel_bus_receiver #(
  parameter int FIFO_DEPTH  = 8,
  parameter int COLOUR_BITS = 3,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120
) (
  input  logic                        clk,
  input  logic                        reset,
  pixel_bus_receiver_if.slave         bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        busy
`ifdef CLIP_COUNT_EN
  ,
  output logic [15:0]                 clip_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CB = COLOUR_BITS / 3;
  localparam int EW = 8 + 7 + COLOUR_BITS;

  localparam logic [8:0]    SCREEN_W_L = 9'(SCREEN_W);
  localparam logic [8:0]    SCREEN_H_L = 9'(SCREEN_H);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LEVEL_ZERO = LW'(0);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_PLOT  = 1'b1
  } state_t;

  // Keep the top CB bits of each channel, packed {R, G, B}
  function automatic logic [COLOUR_BITS-1:0] reduce_colour(input logic [23:0] rgb);
    reduce_colour = {rgb[23 -: CB], rgb[15 -: CB], rgb[7 -: CB]};
  endfunction

  // Storage and state
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic                   busy_q, busy_d;
  state_t                 state_q, state_d;
  logic [7:0]             fb_x_q, fb_x_d;
  logic [6:0]             fb_y_q, fb_y_d;
  logic [COLOUR_BITS-1:0] fb_colour_q, fb_colour_d;
`ifdef CLIP_COUNT_EN
  logic [15:0]            clip_cnt_q, clip_cnt_d;
`endif

  // Datapath control
  logic          strobe_s;
  logic          in_range_s;
  logic          accept_s;
  logic          clip_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          push_s;
  logic          pop_s;
  logic          drop_s;
  logic [EW-1:0] entry_s;
  logic [EW-1:0] head_s;

  // Qualify the bus strobe: only a solid 1 is a draw; off-screen draws are clipped
  always_comb begin
    strobe_s   = (bus.vga_draw_enable_bus == 1'b1);
    in_range_s = ({1'b0, bus.vga_x_out_bus} < SCREEN_W_L) &&
                 ({1'b0, bus.vga_y_out_bus} < SCREEN_H_L);
    accept_s   = strobe_s && in_range_s;
    clip_s     = strobe_s && !in_range_s;
    entry_s    = {bus.vga_x_out_bus, bus.vga_y_out_bus[6:0],
                  reduce_colour(bus.vga_RGB_out_bus)};
  end

  // Output stage next state: load the FIFO head whenever the output register is free
  always_comb begin
    state_d = state_q;
    pop_s   = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_d = S_PLOT;
        end else begin
          state_d = S_EMPTY;
        end
      end
      S_PLOT: begin
        if (bus.fb_ready) begin
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            state_d = S_PLOT;
          end else begin
            state_d = S_EMPTY;
          end
        end else begin
          state_d = S_PLOT;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  // FIFO bookkeeping; a push into a full FIFO survives only if the same edge pops
  always_comb begin
    fifo_full_s  = (level_q == LEVEL_FULL);
    fifo_empty_s = (level_q == LEVEL_ZERO);
    push_s       = accept_s && (!fifo_full_s || pop_s);
    drop_s       = accept_s && fifo_full_s && !pop_s;
    head_s       = mem_q[rd_ptr_q];
    wr_ptr_d     = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d     = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
    overflow_d = overflow_q || drop_s;
  end

  // Output register and status next values; pixel fields hold unless a new head is loaded
  always_comb begin
    if (pop_s) begin
      fb_x_d      = head_s[EW-1 -: 8];
      fb_y_d      = head_s[COLOUR_BITS +: 7];
      fb_colour_d = head_s[COLOUR_BITS-1:0];
    end else begin
      fb_x_d      = fb_x_q;
      fb_y_d      = fb_y_q;
      fb_colour_d = fb_colour_q;
    end
    busy_d = (level_d != LEVEL_ZERO) || (state_d == S_PLOT);
  end

`ifdef CLIP_COUNT_EN
  // Saturating count of clipped strobes
  always_comb begin
    if (clip_s && (clip_cnt_q != 16'hFFFF)) begin
      clip_cnt_d = clip_cnt_q + 16'd1;
    end else begin
      clip_cnt_d = clip_cnt_q;
    end
  end
`endif

  // FIFO storage write; contents are don't-care until the pointers say otherwise
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  // State, pointer, output and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      fb_x_q      <= 8'd0;
      fb_y_q      <= 7'd0;
      fb_colour_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      fb_x_q      <= fb_x_d;
      fb_y_q      <= fb_y_d;
      fb_colour_q <= fb_colour_d;
    end
  end

`ifdef CLIP_COUNT_EN
  // Clip counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      clip_cnt_q <= 16'd0;
    end else begin
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign clip_count = clip_cnt_q;
`endif

  assign bus.fb_x      = fb_x_q;
  assign bus.fb_y      = fb_y_q;
  assign bus.fb_colour = fb_colour_q;
  assign bus.fb_plot   = (state_q == S_PLOT);
  assign fifo_level    = level_q;
  assign overflow      = overflow_q;
  assign busy          = busy_q;

endmodule
